// File: rtl/mem_line_arbiter.sv
`timescale 1ns/1ps
// mem_line_arbiter
//
// Shares one word-wide backing memory port between the I-cache refill path
// and the D-cache refill/writeback path. Each requester asks for a whole line.
// A round-robin choice picks one requester. The block then runs LINE_WORDS
// single-word beats against memory. It returns the line together with a
// one-cycle done pulse.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   ic_req/ic_addr       I-cache line read request (held until ic_done)
//   ic_done/ic_rdata     completion pulse and line data (valid only with done)
//   dc_req/dc_we/dc_addr D-cache request; dc_we=1 means line writeback
//   dc_wdata             writeback line (word 0 in the low bits)
//   dc_done/dc_rdata     completion pulse; refill data or echo of dc_wdata
//   mem_*                single-word memory beat interface
//   busy                 high while a transaction is transferring or responding
//   ic_grants/dc_grants  saturating grant counters
module mem_line_arbiter #(
  parameter int XLEN           = 32,
  parameter int LINE_WORDS     = 4,
  parameter int LINE_ADDR_BITS = 4,
  parameter int CNT_BITS       = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        ic_req,
  input  logic [LINE_ADDR_BITS-1:0]                   ic_addr,
  output logic                                        ic_done,
  output logic [LINE_WORDS*XLEN-1:0]                  ic_rdata,
  input  logic                                        dc_req,
  input  logic                                        dc_we,
  input  logic [LINE_ADDR_BITS-1:0]                   dc_addr,
  input  logic [LINE_WORDS*XLEN-1:0]                  dc_wdata,
  output logic                                        dc_done,
  output logic [LINE_WORDS*XLEN-1:0]                  dc_rdata,
  output logic                                        mem_req,
  output logic                                        mem_we,
  output logic [LINE_ADDR_BITS+$clog2(LINE_WORDS)-1:0] mem_addr,
  output logic [XLEN-1:0]                             mem_wdata,
  input  logic [XLEN-1:0]                             mem_rdata,
  input  logic                                        mem_ready,
  output logic                                        busy,
  output logic [CNT_BITS-1:0]                         ic_grants,
  output logic [CNT_BITS-1:0]                         dc_grants
);

  localparam int BEAT_BITS = $clog2(LINE_WORDS);
  localparam int LINE_W    = LINE_WORDS * XLEN;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [BEAT_BITS-1:0]      beat_q, beat_d;
  logic                      last_gnt_q, last_gnt_d; // 1 = D-cache was granted last
  logic                      sel_q, sel_d;           // 1 = D-cache owns the transaction
  logic [LINE_ADDR_BITS-1:0] addr_q, addr_d;
  logic                      we_q, we_d;
  logic [LINE_W-1:0]         buf_q, buf_d;
  logic [CNT_BITS-1:0]       ic_cnt_q, ic_cnt_d;
  logic [CNT_BITS-1:0]       dc_cnt_q, dc_cnt_d;
  logic                      gnt_dc;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  // D wins when it is the only requester, or on a tie when I was served last.
  assign gnt_dc = dc_req && (!ic_req || !last_gnt_q);

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_gnt_d = last_gnt_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    we_d       = we_q;
    buf_d      = buf_q;
    ic_cnt_d   = ic_cnt_q;
    dc_cnt_d   = dc_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (ic_req || dc_req) begin
          sel_d      = gnt_dc;
          addr_d     = gnt_dc ? dc_addr : ic_addr;
          we_d       = gnt_dc && dc_we;
          // A writeback streams its data out of the buffer; reads fill it.
          buf_d      = (gnt_dc && dc_we) ? dc_wdata : '0;
          beat_d     = '0;
          last_gnt_d = gnt_dc;
          if (gnt_dc) dc_cnt_d = sat_inc(dc_cnt_q);
          else        ic_cnt_d = sat_inc(ic_cnt_q);
          state_d    = ST_XFER;
        end
      end

      ST_XFER: begin
        if (mem_ready) begin
          if (!we_q) buf_d[beat_q*XLEN +: XLEN] = mem_rdata;
          if (beat_q == LAST_BEAT) state_d = ST_RESP;
          else                     beat_d  = beat_q + BEAT_BITS'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      last_gnt_q <= 1'b0;
      sel_q      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      buf_q      <= '0;
      ic_cnt_q   <= '0;
      dc_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_gnt_q <= last_gnt_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      buf_q      <= buf_d;
      ic_cnt_q   <= ic_cnt_d;
      dc_cnt_q   <= dc_cnt_d;
    end
  end

  // Outputs are gated by state so that everything idles at zero.
  always_comb begin
    mem_req   = (state_q == ST_XFER);
    mem_we    = mem_req && we_q;
    mem_addr  = mem_req ? {addr_q, beat_q} : '0;
    mem_wdata = mem_req ? buf_q[beat_q*XLEN +: XLEN] : '0;
    busy      = (state_q == ST_XFER) || (state_q == ST_RESP);
    ic_done   = (state_q == ST_RESP) && !sel_q;
    dc_done   = (state_q == ST_RESP) &&  sel_q;
    ic_rdata  = ic_done ? buf_q : '0;
    dc_rdata  = dc_done ? buf_q : '0;
    ic_grants = ic_cnt_q;
    dc_grants = dc_cnt_q;
  end

endmodule

// File: tb/tb_mem_line_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_line_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level reference of line memory,
// round-robin arbitration and grant counting.
module tb_mem_line_arbiter;

  localparam int LW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req;
  logic [3:0]   ic_addr;
  logic         ic_done;
  logic [127:0] ic_rdata;
  logic         dc_req;
  logic         dc_we;
  logic [3:0]   dc_addr;
  logic [127:0] dc_wdata;
  logic         dc_done;
  logic [127:0] dc_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [5:0]   mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_ready;
  logic         busy;
  logic [15:0]  ic_grants;
  logic [15:0]  dc_grants;

  // Second instance with narrow counters for the saturation scenario.
  logic         s_ic_req;
  logic         s_ic_done;
  logic [127:0] s_ic_rdata;
  logic         s_dc_done;
  logic [127:0] s_dc_rdata;
  logic         s_mem_req;
  logic         s_mem_we;
  logic [5:0]   s_mem_addr;
  logic [31:0]  s_mem_wdata;
  logic         s_busy;
  logic [1:0]   s_ic_grants;
  logic [1:0]   s_dc_grants;

  always #5 clk = ~clk;

  mem_line_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .ic_grants(ic_grants), .dc_grants(dc_grants)
  );

  mem_line_arbiter #(.CNT_BITS(2)) u_sat (
    .clk(clk), .rst(rst),
    .ic_req(s_ic_req), .ic_addr(4'd7), .ic_done(s_ic_done), .ic_rdata(s_ic_rdata),
    .dc_req(1'b0), .dc_we(1'b0), .dc_addr(4'd0), .dc_wdata(128'd0),
    .dc_done(s_dc_done), .dc_rdata(s_dc_rdata),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(32'hC0DE_0001), .mem_ready(1'b1),
    .busy(s_busy), .ic_grants(s_ic_grants), .dc_grants(s_dc_grants)
  );

  // Backing memory driven by the bench, and the reference view of it per line.
  logic [31:0]  tb_mem [64];
  logic [127:0] ref_line [16];
  int           last_m;   // 0 = I served last, 1 = D served last
  int           ic_m, dc_m;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_mem_drive();
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_flags"}, {ic_done, dc_done, mem_req, mem_we, busy}, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
    chk({tag, "_ic_rdata"}, ic_rdata, 0);
    chk({tag, "_dc_rdata"}, dc_rdata, 0);
    chk({tag, "_grants"}, {ic_grants, dc_grants}, 0);
  endtask

  // One arbitration episode starting in an idle cycle. want_i/want_d select
  // the requesters; stalls<0 means random mem_ready, otherwise a fixed number
  // of not-ready cycles before every beat.
  task automatic run_txn(input bit want_i, input bit want_d, input bit d_we,
                         input logic [3:0] ia, input logic [3:0] da,
                         input logic [127:0] dwd, input int stalls);
    int first;
    int cur;
    int beat;
    int st;
    int a;
    bit we;
    bit rdy;
    logic [3:0]   la;
    logic [127:0] exp_line;
    ic_req   = want_i;
    ic_addr  = ia;
    dc_req   = want_d;
    dc_we    = d_we;
    dc_addr  = da;
    dc_wdata = dwd;
    idle_mem_drive();
    first = (want_i && want_d) ? (last_m == 0 ? 1 : 0) : (want_d ? 1 : 0);
    for (int k = 0; k < ((want_i && want_d) ? 2 : 1); k++) begin
      cur = (k == 0) ? first : 1 - first;
      chk("idle_busy", {busy, mem_req}, 0);
      last_m = cur;
      if (cur == 1) dc_m = (dc_m == 16'hFFFF) ? dc_m : dc_m + 1;
      else          ic_m = (ic_m == 16'hFFFF) ? ic_m : ic_m + 1;
      we       = (cur == 1) && d_we;
      la       = (cur == 1) ? da : ia;
      exp_line = we ? dwd : ref_line[la];
      beat = 0;
      st   = 0;
      while (beat < LW) begin
        @(posedge clk); #1;
        a = int'(la) * LW + beat;
        chk("xfer_req", {mem_req, busy, ic_done, dc_done}, 4'b1100);
        chk("xfer_addr", mem_addr, a);
        chk("xfer_we", mem_we, we);
        if (we) chk("xfer_wdata", mem_wdata, dwd[beat*32 +: 32]);
        if (stalls < 0) rdy = ($urandom_range(0, 2) != 0) || (st >= 3);
        else            rdy = (st >= stalls);
        if (rdy) begin
          if (we) tb_mem[a] = mem_wdata;
          mem_rdata = we ? $urandom : tb_mem[a];
          beat++;
          st = 0;
        end else begin
          mem_rdata = $urandom;
          st++;
        end
        mem_ready = rdy;
      end
      @(posedge clk); #1;
      idle_mem_drive();
      chk("resp_busy", {busy, mem_req}, 2'b10);
      if (cur == 1) begin
        chk("dc_done", {dc_done, ic_done}, 2'b10);
        chk("dc_rdata", dc_rdata, exp_line);
        chk("ic_rdata_quiet", ic_rdata, 0);
        if (we) ref_line[la] = dwd;
        dc_req = 1'b0;
      end else begin
        chk("ic_done", {ic_done, dc_done}, 2'b10);
        chk("ic_rdata", ic_rdata, exp_line);
        chk("dc_rdata_quiet", dc_rdata, 0);
        ic_req = 1'b0;
      end
      @(posedge clk); #1;
      idle_mem_drive();
    end
    chk("ic_grants", ic_grants, ic_m);
    chk("dc_grants", dc_grants, dc_m);
  endtask

  initial begin
    logic [127:0] line;
    int kind;
    rst      = 1'b0;
    ic_req   = 1'b0;
    ic_addr  = '0;
    dc_req   = 1'b0;
    dc_we    = 1'b0;
    dc_addr  = '0;
    dc_wdata = '0;
    s_ic_req = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    last_m = 0;
    ic_m   = 0;
    dc_m   = 0;
    for (int i = 0; i < 64; i++) tb_mem[i] = $urandom;
    tb_mem[12] = 32'h11; tb_mem[13] = 32'h22; tb_mem[14] = 32'h33; tb_mem[15] = 32'h44;
    for (int l = 0; l < 16; l++)
      ref_line[l] = {tb_mem[l*4+3], tb_mem[l*4+2], tb_mem[l*4+1], tb_mem[l*4]};

    // Reset state
    #1;
    chk_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests after reset: D, then I, then D again
    run_txn(1, 1, 0, 4'd2, 4'd9, 128'd0, 0);
    run_txn(0, 1, 0, 4'd0, 4'd1, 128'd0, 0);
    chk("rr_counts", {ic_grants, dc_grants}, {16'd1, 16'd2});

    // Single I read of line 3
    run_txn(1, 0, 0, 4'd3, 4'd0, 128'd0, 0);
    chk("line3_data", ref_line[3], {32'h44, 32'h33, 32'h22, 32'h11});

    // D writeback of line 5
    line = {32'hD, 32'hC, 32'hB, 32'hA};
    run_txn(0, 1, 1, 4'd0, 4'd5, line, 0);
    chk("backing_line5", {tb_mem[23], tb_mem[22], tb_mem[21], tb_mem[20]}, line);
    run_txn(1, 0, 0, 4'd5, 4'd0, 128'd0, 0);

    // Two wait states before every beat
    run_txn(1, 0, 0, 4'd8, 4'd0, 128'd0, 2);
    run_txn(0, 1, 0, 4'd0, 4'd3, 128'd0, 2);

    // Reset in the middle of a D read
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 4'd6;
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;                 // granted, beat 0
    @(posedge clk); #1;                 // beat 1
    chk("pre_reset_beat", mem_addr, 6'd25);
    rst = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    dc_req = 1'b0;
    @(posedge clk); #1;
    chk("reset_no_done", {dc_done, ic_done, busy}, 0);
    rst = 1'b1;
    last_m = 0;
    ic_m   = 0;
    dc_m   = 0;
    @(posedge clk); #1;
    chk("post_reset_idle", {busy, dc_done}, 0);
    run_txn(0, 1, 0, 4'd0, 4'd6, 128'd0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      line = {$urandom, $urandom, $urandom, $urandom};
      run_txn(kind != 1, kind != 0, 1'($urandom), 4'($urandom), 4'($urandom), line, -1);
    end

    // Counter saturation on the 2-bit instance
    for (int i = 1; i <= 5; i++) begin
      s_ic_req = 1'b1;
      for (int c = 0; c < 20 && !s_ic_done; c++) begin
        @(posedge clk); #1;
      end
      chk("sat_done", s_ic_done, 1'b1);
      chk("sat_rdata", s_ic_rdata, {4{32'hC0DE_0001}});
      s_ic_req = 1'b0;
      @(posedge clk); #1;
      chk("sat_grants", s_ic_grants, (i > 3) ? 3 : i);
    end
    chk("sat_idle", {s_dc_done, s_mem_req, s_mem_we, s_busy, s_dc_grants}, 0);
    chk("sat_idle_bus", {s_dc_rdata, s_mem_addr, s_mem_wdata}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
